// File: rtl/lt24_pixel_arbiter.sv
// Two-requester arbiter in front of the LT24Display pixel write port: round-robin
// grants per burst, zero-latency pass-through, off-screen beat filtering and stall timeout.
module lt24_pixel_arbiter #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [7:0]  req0_x,
    input  logic [8:0]  req0_y,
    input  logic [15:0] req0_data,
    input  logic        req0_last,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [7:0]  req1_x,
    input  logic [8:0]  req1_y,
    input  logic [15:0] req1_data,
    input  logic        req1_last,
    output logic        req1_ready,

    output logic [7:0]  xAddr,
    output logic [8:0]  yAddr,
    output logic [15:0] pixelData,
    output logic        pixelWrite,
    input  logic        pixelReady,

    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout_pulse,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [8:0] LP_WIDTH      = 9'(WIDTH);
    localparam logic [9:0] LP_HEIGHT     = 10'(HEIGHT);
    localparam logic [7:0] LP_STALL_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_last_served;
    logic        w_last_served_next;
    logic [7:0]  r_stall;
    logic [7:0]  w_stall_next;
    logic        r_timeout_pulse;
    logic        w_timeout_pulse_next;
    logic [7:0]  r_drop_count;
    logic [7:0]  w_drop_count_next;

    logic        w_req_valid [2];
    logic [7:0]  w_req_x     [2];
    logic [8:0]  w_req_y     [2];
    logic [15:0] w_req_data  [2];
    logic        w_req_last  [2];

    logic [1:0]  w_grant;
    logic [1:0]  w_req_ready;
    logic        w_owned;
    logic        w_owner;
    logic        w_own_valid;
    logic [7:0]  w_own_x;
    logic [8:0]  w_own_y;
    logic [15:0] w_own_data;
    logic        w_own_last;
    logic        w_out_of_range;
    logic        w_accept;

    assign w_req_valid[0] = req0_valid;
    assign w_req_x[0]     = req0_x;
    assign w_req_y[0]     = req0_y;
    assign w_req_data[0]  = req0_data;
    assign w_req_last[0]  = req0_last;
    assign w_req_valid[1] = req1_valid;
    assign w_req_x[1]     = req1_x;
    assign w_req_y[1]     = req1_y;
    assign w_req_data[1]  = req1_data;
    assign w_req_last[1]  = req1_last;

    assign w_grant = {r_state == OWN1, r_state == OWN0};
    assign w_owned = |w_grant;
    assign w_owner = w_grant[1];

    assign w_own_valid = w_req_valid[w_owner];
    assign w_own_x     = w_req_x[w_owner];
    assign w_own_y     = w_req_y[w_owner];
    assign w_own_data  = w_req_data[w_owner];
    assign w_own_last  = w_req_last[w_owner];

    assign w_out_of_range = ({1'b0, w_own_x} >= LP_WIDTH) || ({1'b0, w_own_y} >= LP_HEIGHT);

    // Off-screen beats are swallowed without waiting on the display; nothing is
    // accepted while reset is high so an interrupted burst cannot advance.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign w_req_ready[gi] = w_grant[gi] & ~reset & (w_out_of_range | pixelReady);
        end
    endgenerate

    assign w_accept = w_own_valid & w_req_ready[w_owner];

    assign req0_ready    = w_req_ready[0];
    assign req1_ready    = w_req_ready[1];
    assign grant         = w_grant;
    assign busy          = w_owned;
    assign timeout_pulse = r_timeout_pulse;
    assign drop_count    = r_drop_count;

    always_comb begin
        xAddr      = '0;
        yAddr      = '0;
        pixelData  = '0;
        pixelWrite = 1'b0;
        if (w_owned) begin
            xAddr      = w_own_x;
            yAddr      = w_own_y;
            pixelData  = w_own_data;
            pixelWrite = w_own_valid & ~w_out_of_range & ~reset;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_last_served_next   = r_last_served;
        w_stall_next         = r_stall;
        w_timeout_pulse_next = 1'b0;
        w_drop_count_next    = r_drop_count;

        unique case (r_state)
            IDLE: begin
                w_stall_next = '0;
                if (req0_valid && req1_valid) begin
                    w_state_next = r_last_served ? OWN0 : OWN1;
                end else if (req0_valid) begin
                    w_state_next = OWN0;
                end else if (req1_valid) begin
                    w_state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (w_own_valid) begin
                    w_stall_next = '0;
                    if (w_accept && w_out_of_range && (r_drop_count != 8'hFF)) begin
                        w_drop_count_next = r_drop_count + 8'd1;
                    end
                    if (w_accept && w_own_last) begin
                        w_state_next       = IDLE;
                        w_last_served_next = w_owner;
                    end
                end else if (r_stall == LP_STALL_LAST) begin
                    // This is the TIMEOUT-th consecutive stalled cycle: revoke.
                    w_state_next         = IDLE;
                    w_last_served_next   = w_owner;
                    w_stall_next         = '0;
                    w_timeout_pulse_next = 1'b1;
                end else begin
                    w_stall_next = r_stall + 8'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_last_served   <= 1'b1;
            r_stall         <= '0;
            r_timeout_pulse <= 1'b0;
            r_drop_count    <= '0;
        end else begin
            r_state         <= w_state_next;
            r_last_served   <= w_last_served_next;
            r_stall         <= w_stall_next;
            r_timeout_pulse <= w_timeout_pulse_next;
            r_drop_count    <= w_drop_count_next;
        end
    end

endmodule

// File: tb/tb_lt24_pixel_arbiter.sv
// Bench for lt24_pixel_arbiter: directed scenarios plus randomized two-requester
// traffic checked against per-requester ordered write queues.
`timescale 1ns/1ps
module tb_lt24_pixel_arbiter;

    logic        clock;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_x, req1_x;
    logic [8:0]  req0_y, req1_y;
    logic [15:0] req0_data, req1_data;
    logic        req0_last, req1_last;
    logic        req0_ready, req1_ready;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout_pulse;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    lt24_pixel_arbiter #(.WIDTH(240), .HEIGHT(320), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
        .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
        .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
        .pixelWrite(pixelWrite), .pixelReady(pixelReady),
        .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse),
        .drop_count(drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_x = 0; req0_y = 0; req0_data = 0; req0_last = 0;
        req1_valid = 0; req1_x = 0; req1_y = 0; req1_data = 0; req1_last = 0;
        pixelReady = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req0_valid = 1; req0_x = 8'd5; req0_y = 9'd6; req0_data = 16'h1234;
        req1_valid = 1; req1_x = 8'd7; req1_y = 9'd8;
        pixelReady = 1;
        reset = 1;
        tick();
        tick();
        @(negedge clock);
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (pixelWrite !== 1'b0) begin n_fail++; $display("FAIL reset_pixelWrite: got %b expected 0", pixelWrite); end
        n_checks++; if ({xAddr, yAddr, pixelData} !== 33'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", {xAddr, yAddr, pixelData}); end
        n_checks++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_pulse); end
        n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
        n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
        reset = 0;
        idle_inputs();
        tick();
        $display("[tb] test_reset done");
    endtask

    task automatic test_single_burst();
        logic [15:0] d [3];
        do_reset();
        pixelReady = 1;
        for (int i = 0; i < 3; i++) d[i] = 16'($urandom);
        req0_valid = 1; req0_x = 0; req0_y = 9'd5; req0_data = d[0]; req0_last = 0;
        @(negedge clock);
        n_checks++; if ({grant, req0_ready, pixelWrite} !== 4'b0000) begin n_fail++; $display("FAIL single_latency: got grant/ready/write %b expected 0000", {grant, req0_ready, pixelWrite}); end
        tick();
        for (int b = 0; b < 3; b++) begin
            @(negedge clock);
            n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant beat %0d: got %b expected 01", b, grant); end
            n_checks++; if (pixelWrite !== 1'b1 || req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_write beat %0d: got write %b ready %b expected 1 1", b, pixelWrite, req0_ready); end
            n_checks++; if ({xAddr, yAddr, pixelData} !== {8'(b), 9'd5, d[b]}) begin n_fail++; $display("FAIL single_data beat %0d: got %h expected %h", b, {xAddr, yAddr, pixelData}, {8'(b), 9'd5, d[b]}); end
            tick();
            if (b < 2) begin
                req0_x = 8'(b + 1); req0_data = d[b + 1]; req0_last = (b + 1 == 2);
            end else begin
                req0_valid = 0; req0_last = 0;
            end
        end
        @(negedge clock);
        n_checks++; if ({grant, busy} !== 3'b000) begin n_fail++; $display("FAIL single_end: got grant/busy %b expected 000", {grant, busy}); end
        tick();
        $display("[tb] test_single_burst done");
    endtask

    task automatic test_contention();
        logic [1:0] exp_pat [6];
        int k0, k1;
        bit a0, a1;
        exp_pat = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        k0 = 0; k1 = 0;
        idle_inputs();
        pixelReady = 1;
        req0_valid = 1; req1_valid = 1;
        reset = 1;
        tick();
        tick();
        reset = 0;
        for (int c = 0; c < 18; c++) begin
            req0_x = 8'(k0); req0_y = 9'd1; req0_last = (k0 % 2 == 1);
            req1_x = 8'(100 + k1); req1_y = 9'd2; req1_last = (k1 % 2 == 1);
            @(negedge clock);
            n_checks++; if (grant !== exp_pat[c % 6]) begin n_fail++; $display("FAIL contention_grant cycle %0d: got %b expected %b", c, grant, exp_pat[c % 6]); end
            if (exp_pat[c % 6] == 2'b01) begin
                n_checks++; if (xAddr !== 8'(k0)) begin n_fail++; $display("FAIL contention_x0 cycle %0d: got %0d expected %0d", c, xAddr, k0); end
            end else if (exp_pat[c % 6] == 2'b10) begin
                n_checks++; if (xAddr !== 8'(100 + k1)) begin n_fail++; $display("FAIL contention_x1 cycle %0d: got %0d expected %0d", c, xAddr, 100 + k1); end
            end
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            tick();
            if (a0) k0++;
            if (a1) k1++;
        end
        n_checks++; if (k0 != 6 || k1 != 6) begin n_fail++; $display("FAIL contention_beats: got %0d/%0d expected 6/6", k0, k1); end
        idle_inputs();
        tick();
        $display("[tb] test_contention done");
    endtask

    task automatic test_backpressure();
        int b, stall_left;
        bit acc;
        logic [7:0] wr [$];
        do_reset();
        b = 0; stall_left = 4;
        for (int c = 0; c < 40 && b < 4; c++) begin
            req0_valid = 1; req0_x = 8'(10 + b); req0_y = 9'd20;
            req0_data = 16'hA000 + 16'(b); req0_last = (b == 3);
            pixelReady = !(b == 1 && stall_left > 0);
            @(negedge clock);
            if (!pixelReady) begin
                n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b expected 0", req0_ready); end
                n_checks++; if (xAddr !== 8'd11 || pixelData !== 16'hA001) begin n_fail++; $display("FAIL bp_hold: got x %0d data %h expected 11 a001", xAddr, pixelData); end
            end
            if (pixelWrite && pixelReady) wr.push_back(xAddr);
            acc = req0_valid && req0_ready;
            tick();
            if (!pixelReady) stall_left--;
            if (acc) b++;
        end
        req0_valid = 0; req0_last = 0;
        n_checks++; if (b != 4) begin n_fail++; $display("FAIL bp_complete: got %0d beats expected 4", b); end
        n_checks++; if (wr.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d writes expected 4", wr.size()); end
        for (int i = 0; i < wr.size() && i < 4; i++) begin
            n_checks++; if (wr[i] !== 8'(10 + i)) begin n_fail++; $display("FAIL bp_order %0d: got %0d expected %0d", i, wr[i], 10 + i); end
        end
        @(negedge clock);
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL bp_end: got %b expected 00", grant); end
        tick();
        $display("[tb] test_backpressure done");
    endtask

    task automatic test_out_of_range();
        int total, sent, exp_dc;
        bit wrote, acc, need_new;
        do_reset();
        pixelReady = 0;
        req1_valid = 1; req1_x = 8'd240; req1_y = 9'd10; req1_data = 16'hBEEF; req1_last = 0;
        @(negedge clock);
        tick();
        @(negedge clock);
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL oor_grant: got %b expected 10", grant); end
        n_checks++; if (pixelWrite !== 1'b0 || req1_ready !== 1'b1) begin n_fail++; $display("FAIL oor_drop: got write %b ready %b expected 0 1", pixelWrite, req1_ready); end
        tick();
        req1_x = 8'd239; req1_y = 9'd319; req1_data = 16'h5A5A; req1_last = 1; pixelReady = 1;
        @(negedge clock);
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL oor_count1: got %0d expected 1", drop_count); end
        n_checks++; if ({pixelWrite, xAddr, yAddr} !== {1'b1, 8'd239, 9'd319}) begin n_fail++; $display("FAIL oor_edge_write: got %h expected %h", {pixelWrite, xAddr, yAddr}, {1'b1, 8'd239, 9'd319}); end
        tick();
        req1_valid = 0; req1_last = 0;
        @(negedge clock);
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL oor_end: got %b expected 00", grant); end
        tick();
        total = 1; sent = 0; wrote = 0; need_new = 1;
        for (int c = 0; c < 1000 && sent < 300; c++) begin
            req1_valid = 1;
            if (need_new) begin
                if ($urandom % 2 == 0) begin
                    req1_x = 8'(240 + $urandom % 16); req1_y = 9'($urandom % 320);
                end else begin
                    req1_x = 8'($urandom % 240); req1_y = 9'(320 + $urandom % 192);
                end
                req1_data = 16'($urandom);
                need_new = 0;
            end
            req1_last = (sent == 299);
            pixelReady = $urandom % 2;
            @(negedge clock);
            if (pixelWrite) wrote = 1;
            acc = req1_valid && req1_ready;
            tick();
            if (acc) begin
                sent++; total++; need_new = 1;
                if (sent % 50 == 0) begin
                    exp_dc = (total > 255) ? 255 : total;
                    n_checks++; if (drop_count !== 8'(exp_dc)) begin n_fail++; $display("FAIL oor_saturate after %0d: got %0d expected %0d", total, drop_count, exp_dc); end
                end
            end
        end
        req1_valid = 0; req1_last = 0;
        n_checks++; if (sent != 300) begin n_fail++; $display("FAIL oor_bulk_sent: got %0d expected 300", sent); end
        n_checks++; if (wrote) begin n_fail++; $display("FAIL oor_bulk_write: got pixelWrite 1 expected 0"); end
        tick();
        $display("[tb] test_out_of_range done");
    endtask

    task automatic test_timeout();
        int held, pulses;
        do_reset();
        pixelReady = 1;
        req0_valid = 1; req0_x = 8'd1; req0_y = 9'd1; req0_last = 0;
        @(negedge clock);
        tick();
        @(negedge clock);
        n_checks++; if (grant !== 2'b01 || req0_ready !== 1'b1) begin n_fail++; $display("FAIL to_grant0: got grant %b ready %b expected 01 1", grant, req0_ready); end
        tick();
        req0_valid = 0;
        req1_valid = 1; req1_x = 8'd7; req1_y = 9'd7; req1_data = 16'h0707; req1_last = 1;
        held = 0; pulses = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clock);
            if (grant == 2'b01) held++;
            if (timeout_pulse) pulses++;
            tick();
        end
        n_checks++; if (held != 64) begin n_fail++; $display("FAIL to_held: got %0d cycles expected 64", held); end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL to_early_pulse: got %0d expected 0", pulses); end
        @(negedge clock);
        n_checks++; if (grant !== 2'b00 || timeout_pulse !== 1'b1) begin n_fail++; $display("FAIL to_revoke: got grant %b pulse %b expected 00 1", grant, timeout_pulse); end
        tick();
        @(negedge clock);
        n_checks++; if (grant !== 2'b10 || timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL to_next: got grant %b pulse %b expected 10 0", grant, timeout_pulse); end
        n_checks++; if (pixelWrite !== 1'b1 || xAddr !== 8'd7) begin n_fail++; $display("FAIL to_req1_write: got write %b x %0d expected 1 7", pixelWrite, xAddr); end
        tick();
        req1_valid = 0; req1_last = 0;
        @(negedge clock);
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL to_end: got %b expected 00", grant); end
        tick();
        $display("[tb] test_timeout done");
    endtask

    task automatic test_reset_mid_burst();
        int b;
        bit acc;
        do_reset();
        pixelReady = 1;
        // A completed req0 burst makes req1 the round-robin favourite unless reset clears it.
        req0_valid = 1; req0_x = 8'd3; req0_y = 9'd3; req0_last = 1;
        @(negedge clock); tick();
        @(negedge clock); tick();
        req0_valid = 0; req0_last = 0;
        @(negedge clock); tick();
        b = 0;
        for (int c = 0; c < 10 && b < 2; c++) begin
            req0_valid = 1; req0_x = 8'(50 + b); req0_y = 9'd4; req0_last = 0;
            @(negedge clock);
            acc = req0_valid && req0_ready;
            tick();
            if (acc) b++;
        end
        n_checks++; if (b != 2) begin n_fail++; $display("FAIL rmb_start: got %0d beats expected 2", b); end
        req0_x = 8'd52;
        req1_valid = 1; req1_x = 8'd9; req1_y = 9'd9; req1_last = 0;
        reset = 1;
        @(negedge clock);
        n_checks++; if ({req0_ready, pixelWrite, timeout_pulse} !== 3'b000) begin n_fail++; $display("FAIL rmb_reset_cycle: got ready/write/pulse %b expected 000", {req0_ready, pixelWrite, timeout_pulse}); end
        tick();
        reset = 0;
        @(negedge clock);
        n_checks++; if ({grant, pixelWrite, timeout_pulse} !== 4'b0000) begin n_fail++; $display("FAIL rmb_after: got grant/write/pulse %b expected 0000", {grant, pixelWrite, timeout_pulse}); end
        tick();
        @(negedge clock);
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rmb_rearb: got %b expected 01", grant); end
        tick();
        $display("[tb] test_reset_mid_burst done");
    endtask

    task automatic test_random_traffic();
        logic [33:0] beats0 [$];
        logic [33:0] beats1 [$];
        logic [32:0] exp0 [$];
        logic [32:0] exp1 [$];
        logic [32:0] got, e;
        logic [33:0] bt;
        logic [1:0]  prev_g;
        int ptr0, ptr1, gap0, gap1, oor, len;
        bit a0, a1, done, bad_x;
        logic [7:0] x;
        logic [8:0] y;
        logic [15:0] d;
        oor = 0;
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 6; k++) begin
                len = 1 + $urandom % 5;
                for (int i = 0; i < len; i++) begin
                    x = 8'($urandom % 240); y = 9'($urandom % 320); d = 16'($urandom);
                    if ($urandom % 10 == 0) begin
                        bad_x = $urandom % 2;
                        if (bad_x) x = 8'(240 + $urandom % 16);
                        else y = 9'(320 + $urandom % 192);
                        oor++;
                    end
                    bt = {(i == len - 1), x, y, d};
                    if (n == 0) beats0.push_back(bt); else beats1.push_back(bt);
                    if (x < 240 && y < 320) begin
                        if (n == 0) exp0.push_back({x, y, d}); else exp1.push_back({x, y, d});
                    end
                end
            end
        end
        do_reset();
        ptr0 = 0; ptr1 = 0; gap0 = 0; gap1 = 0; prev_g = 2'b00; done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (ptr0 < beats0.size() && gap0 == 0) begin
                req0_valid = 1; {req0_last, req0_x, req0_y, req0_data} = beats0[ptr0];
            end else begin
                req0_valid = 0; if (gap0 > 0) gap0--;
            end
            if (ptr1 < beats1.size() && gap1 == 0) begin
                req1_valid = 1; {req1_last, req1_x, req1_y, req1_data} = beats1[ptr1];
            end else begin
                req1_valid = 0; if (gap1 > 0) gap1--;
            end
            pixelReady = ($urandom % 4 != 0);
            @(negedge clock);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            got = {xAddr, yAddr, pixelData};
            if (pixelWrite && pixelReady) begin
                n_checks++;
                if (grant == 2'b01 && exp0.size() > 0) begin
                    e = exp0.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL rnd_write0: got %h expected %h", got, e); end
                end else if (grant == 2'b10 && exp1.size() > 0) begin
                    e = exp1.pop_front();
                    if (got !== e) begin n_fail++; $display("FAIL rnd_write1: got %h expected %h", got, e); end
                end else begin
                    n_fail++; $display("FAIL rnd_unexpected_write: got grant %b data %h expected no write", grant, got);
                end
            end
            n_checks++;
            if ((grant == 2'b11) || (busy !== (|grant)) ||
                (prev_g != 2'b00 && grant != 2'b00 && grant != prev_g)) begin
                n_fail++; $display("FAIL rnd_grant: got %b after %b busy %b expected legal handover", grant, prev_g, busy);
            end
            prev_g = grant;
            tick();
            if (a0) begin ptr0++; gap0 = $urandom % 3; end
            if (a1) begin ptr1++; gap1 = $urandom % 3; end
            if (ptr0 >= beats0.size() && ptr1 >= beats1.size() && grant == 2'b00) done = 1;
        end
        idle_inputs();
        n_checks++; if (!done) begin n_fail++; $display("FAIL rnd_budget: got %0d/%0d beats consumed expected %0d/%0d", ptr0, ptr1, beats0.size(), beats1.size()); end
        n_checks++; if (exp0.size() != 0 || exp1.size() != 0) begin n_fail++; $display("FAIL rnd_missing: got %0d/%0d writes outstanding expected 0/0", exp0.size(), exp1.size()); end
        n_checks++; if (drop_count !== 8'(oor)) begin n_fail++; $display("FAIL rnd_drops: got %0d expected %0d", drop_count, oor); end
        tick();
        $display("[tb] test_random_traffic done: %0d+%0d beats, %0d dropped", beats0.size(), beats1.size(), oor);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_single_burst();
        test_contention();
        test_backpressure();
        test_out_of_range();
        test_timeout();
        test_reset_mid_burst();
        test_random_traffic();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
